// File: rtl/fir_filter_mac_core.sv
// Queue-fed FIR engine: samples pass through an input FIFO into an NTAPS delay line,
// then a single multiplier walks the taps one per clock and a saturated sum is handed out.
module fir_filter_mac_core #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 4,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      write,
    input  logic [DATA_W-1:0]         input_data,
    output logic                      full,
    output logic                      empty,
    input  logic                      coef_wr,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    output logic                      busy,
    input  logic                      read,
    output logic                      sum_valid,
    output logic [ACC_W-1:0]          sum
);
    localparam int TAW    = $clog2(NTAPS);
    localparam int KW     = $clog2(NTAPS + 1);
    localparam int PW     = $clog2(DEPTH);
    localparam int PRODW  = DATA_W + COEF_W;
    localparam int ACCI_W = PRODW + TAW;
    localparam int SW     = ((ACCI_W > ACC_W) ? ACCI_W : ACC_W) + 1;
    localparam logic signed [SW-1:0] SMAX = (SW'(1) << (ACC_W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

    state_e                          state_q, state_d;
    logic [DEPTH-1:0][DATA_W-1:0]    fifo_q;
    logic [PW-1:0]                   wr_ptr_q, rd_ptr_q;
    logic [PW:0]                     count_q, count_d;
    logic                            full_q, empty_q;
    logic [NTAPS-1:0][DATA_W-1:0]    dl_q;
    logic [NTAPS-1:0][COEF_W-1:0]    coef_q;
    logic [KW-1:0]                   k_q, k_d;
    logic [TAW-1:0]                  k_idx;
    logic signed [ACCI_W-1:0]        acc_q, acc_d;
    logic signed [PRODW-1:0]         prod;
    logic signed [SW-1:0]            acc_ext;
    logic [ACC_W-1:0]                sat_val;
    logic [ACC_W-1:0]                sum_q, sum_d;
    logic                            valid_q, valid_d;
    logic                            pop, push, coef_we;

    assign pop     = (state_q == IDLE) && !empty_q;
    // A pop frees a slot in the same cycle, so a write to a full FIFO still lands then.
    assign push    = write && (!full_q || pop);
    assign coef_we = coef_wr && (state_q == IDLE) && empty_q && (int'(coef_addr) < NTAPS);
    assign count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= input_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == (PW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Guard the index on the final load cycle, where k has run one past the last tap.
    assign k_idx   = (k_q < KW'(NTAPS)) ? k_q[TAW-1:0] : '0;
    assign prod    = $signed(dl_q[k_idx]) * $signed(coef_q[k_idx]);
    assign acc_ext = SW'(acc_q);
    assign sat_val = (acc_ext > SMAX) ? ACC_W'(SMAX) :
                     (acc_ext < SMIN) ? ACC_W'(SMIN) : ACC_W'(acc_ext);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: if (pop) begin
                k_d     = '0;
                acc_d   = '0;
                state_d = MAC;
            end
            MAC: if (k_q == KW'(NTAPS)) begin
                sum_d   = sat_val;
                valid_d = 1'b1;
                state_d = DONE;
            end else begin
                acc_d = acc_q + ACCI_W'(prod);
                k_d   = k_q + KW'(1);
            end
            DONE: if (read) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            dl_q    <= '0;
            for (int i = 0; i < NTAPS; i++) coef_q[i] <= (i == 0) ? COEF_W'(1) : '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            if (pop)     dl_q <= {dl_q[NTAPS-2:0], fifo_q[rd_ptr_q]};
            if (coef_we) coef_q[coef_addr] <= coef_data;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign busy      = (state_q != IDLE);
    assign sum_valid = valid_q;
    assign sum       = sum_q;
endmodule
